// File: rtl/diferencial_tx_control_if.sv
// Parallel word handshake into the differential TX sequencer.
// The producer drives the word and its valid flag, and the sequencer answers with ready.
interface diferencial_tx_control_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] dato_in;
    logic              dato_valid;
    logic              dato_ready;

    modport master (
        output dato_in,
        output dato_valid,
        input  dato_ready
    );

    modport slave (
        input  dato_in,
        input  dato_valid,
        output dato_ready
    );
endinterface

// File: rtl/diferencial_tx_control.sv
// Transmit sequencer for the NRZ-L differential emitter. It sends training words on wake,
// serializes data words LSB-first with no gaps, holds the line when starved, then returns it to electrical idle.
module diferencial_tx_control #(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       WAKE_WORDS = 4,
    parameter logic [DATA_W-1:0] TRAIN_WORD = 8'hBC,
    parameter int unsigned       HOLD_CYC   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enb,
    diferencial_tx_control_if.slave  dato,
    output logic                     tx_bit,
    output logic                     tx_elec_idle,
    output logic                     ocupado,
    output logic [1:0]               estado
);

    localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned WORD_W = $clog2(WAKE_WORDS) + 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYC) + 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WAKE_WORDS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAKE = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]        estado_r;
    logic              tx_bit_r;
    logic              tx_elec_idle_r;
    logic              ocupado_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [WORD_W-1:0] word_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [DATA_W-1:0] shreg_r;

    logic [1:0]        estado_s;
    logic              tx_bit_s;
    logic              tx_elec_idle_s;
    logic [BIT_W-1:0]  bit_cnt_s;
    logic [WORD_W-1:0] word_cnt_s;
    logic [HOLD_W-1:0] hold_cnt_s;
    logic [DATA_W-1:0] shreg_s;

    logic              bit_last_s;
    logic              word_last_s;
    logic              hold_last_s;
    logic [BIT_W-1:0]  bit_nxt_s;
    logic              ready_s;
    logic              xfer_s;

    assign bit_last_s  = (bit_cnt_r == BIT_LAST);
    assign word_last_s = (word_cnt_r == WORD_LAST);
    assign hold_last_s = (hold_cnt_r == HOLD_LAST);
    assign bit_nxt_s   = bit_cnt_r + BIT_W'(1'b1);
    assign xfer_s      = ready_s & dato.dato_valid;

    assign dato.dato_ready = ready_s;
    assign tx_bit          = tx_bit_r;
    assign tx_elec_idle    = tx_elec_idle_r;
    assign ocupado         = ocupado_r;
    assign estado          = estado_r;

    // ready opens only at a word boundary, or at any time while the line is held
    always_comb begin
        ready_s = 1'b0;
        case (estado_r)
            ST_WAKE: begin
                if (bit_last_s && word_last_s) begin
                    ready_s = enb;
                end else begin
                    ready_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_last_s) begin
                    ready_s = enb;
                end else begin
                    ready_s = 1'b0;
                end
            end
            ST_HOLD: ready_s = enb;
            default: ready_s = 1'b0;
        endcase
    end

    // next-state and next-output decode; tx_bit_s is the bit the line shows next cycle
    always_comb begin
        estado_s       = estado_r;
        tx_bit_s       = tx_bit_r;
        tx_elec_idle_s = tx_elec_idle_r;
        bit_cnt_s      = bit_cnt_r;
        word_cnt_s     = word_cnt_r;
        hold_cnt_s     = hold_cnt_r;
        shreg_s        = shreg_r;
        case (estado_r)
            ST_IDLE: begin
                bit_cnt_s  = {BIT_W{1'b0}};
                word_cnt_s = {WORD_W{1'b0}};
                hold_cnt_s = {HOLD_W{1'b0}};
                // the waiting word is not consumed here; it is taken at the end of training
                if (enb && dato.dato_valid) begin
                    estado_s       = ST_WAKE;
                    tx_bit_s       = TRAIN_WORD[0];
                    tx_elec_idle_s = 1'b0;
                end else begin
                    estado_s       = ST_IDLE;
                    tx_bit_s       = 1'b0;
                    tx_elec_idle_s = 1'b1;
                end
            end
            ST_WAKE: begin
                tx_elec_idle_s = 1'b0;
                if (bit_last_s) begin
                    bit_cnt_s = {BIT_W{1'b0}};
                    if (word_last_s) begin
                        word_cnt_s = {WORD_W{1'b0}};
                        if (xfer_s) begin
                            estado_s = ST_DATA;
                            tx_bit_s = dato.dato_in[0];
                            shreg_s  = {1'b0, dato.dato_in[DATA_W-1:1]};
                        end else begin
                            estado_s   = ST_HOLD;
                            tx_bit_s   = 1'b0;
                            hold_cnt_s = {HOLD_W{1'b0}};
                        end
                    end else begin
                        word_cnt_s = word_cnt_r + WORD_W'(1'b1);
                        tx_bit_s   = TRAIN_WORD[0];
                    end
                end else begin
                    bit_cnt_s = bit_nxt_s;
                    tx_bit_s  = TRAIN_WORD[bit_nxt_s];
                end
            end
            ST_DATA: begin
                tx_elec_idle_s = 1'b0;
                if (bit_last_s) begin
                    bit_cnt_s = {BIT_W{1'b0}};
                    if (xfer_s) begin
                        estado_s = ST_DATA;
                        tx_bit_s = dato.dato_in[0];
                        shreg_s  = {1'b0, dato.dato_in[DATA_W-1:1]};
                    end else begin
                        estado_s   = ST_HOLD;
                        tx_bit_s   = 1'b0;
                        hold_cnt_s = {HOLD_W{1'b0}};
                    end
                end else begin
                    bit_cnt_s = bit_nxt_s;
                    tx_bit_s  = shreg_r[0];
                    shreg_s   = {1'b0, shreg_r[DATA_W-1:1]};
                end
            end
            ST_HOLD: begin
                tx_elec_idle_s = 1'b0;
                tx_bit_s       = 1'b0;
                if (xfer_s) begin
                    estado_s   = ST_DATA;
                    tx_bit_s   = dato.dato_in[0];
                    shreg_s    = {1'b0, dato.dato_in[DATA_W-1:1]};
                    bit_cnt_s  = {BIT_W{1'b0}};
                    hold_cnt_s = {HOLD_W{1'b0}};
                end else if (hold_last_s) begin
                    estado_s       = ST_IDLE;
                    tx_elec_idle_s = 1'b1;
                    hold_cnt_s     = {HOLD_W{1'b0}};
                end else begin
                    hold_cnt_s = hold_cnt_r + HOLD_W'(1'b1);
                end
            end
            default: begin
                estado_s       = ST_IDLE;
                tx_bit_s       = 1'b0;
                tx_elec_idle_s = 1'b1;
                bit_cnt_s      = {BIT_W{1'b0}};
                word_cnt_s     = {WORD_W{1'b0}};
                hold_cnt_s     = {HOLD_W{1'b0}};
                shreg_s        = {DATA_W{1'b0}};
            end
        endcase
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_r       <= ST_IDLE;
            tx_bit_r       <= 1'b0;
            tx_elec_idle_r <= 1'b1;
            ocupado_r      <= 1'b0;
            bit_cnt_r      <= {BIT_W{1'b0}};
            word_cnt_r     <= {WORD_W{1'b0}};
            hold_cnt_r     <= {HOLD_W{1'b0}};
            shreg_r        <= {DATA_W{1'b0}};
        end else begin
            estado_r       <= estado_s;
            tx_bit_r       <= tx_bit_s;
            tx_elec_idle_r <= tx_elec_idle_s;
            ocupado_r      <= (estado_s != ST_IDLE);
            bit_cnt_r      <= bit_cnt_s;
            word_cnt_r     <= word_cnt_s;
            hold_cnt_r     <= hold_cnt_s;
            shreg_r        <= shreg_s;
        end
    end

endmodule

// File: tb/tb_diferencial_tx_control.sv
// Directed bench for diferencial_tx_control: per-cycle expectations are queued with the stimulus
// and then popped and checked at the falling edge of the same cycle.
module tb_diferencial_tx_control;

    typedef struct packed {
        logic       b;
        logic       idle;
        logic [1:0] st;
        logic       rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic       tx_bit;
    logic       tx_elec_idle;
    logic       ocupado;
    logic [1:0] estado;

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] train_v = 8'hBC;
    logic [7:0] w_v;

    diferencial_tx_control_if #(.DATA_W(8)) dif ();

    diferencial_tx_control dut (
        .clk          (clk),
        .rst          (rst),
        .enb          (enb),
        .dato         (dif),
        .tx_bit       (tx_bit),
        .tx_elec_idle (tx_elec_idle),
        .ocupado      (ocupado),
        .estado       (estado)
    );

    always #5 clk = ~clk;

    task automatic push(input logic b, input logic idle, input logic [1:0] st, input logic rdy);
        exp_t e;
        e.b = b; e.idle = idle; e.st = st; e.rdy = rdy;
        sb_q.push_back(e);
    endtask

    // check the current cycle at the falling edge, then move to just after the next rising edge
    task automatic step(input string tag);
        exp_t e;
        @(negedge clk);
        n_cmp++;
        assert (sb_q.size() > 0) else begin
            n_bad++; $error("FAIL %s scoreboard empty at %0t", tag, $time);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            assert (tx_bit === e.b) else begin
                n_bad++; $error("FAIL %s tx_bit got %b exp %b at %0t", tag, tx_bit, e.b, $time);
            end
            n_cmp++;
            assert (tx_elec_idle === e.idle) else begin
                n_bad++; $error("FAIL %s tx_elec_idle got %b exp %b at %0t", tag, tx_elec_idle, e.idle, $time);
            end
            n_cmp++;
            assert (estado === e.st) else begin
                n_bad++; $error("FAIL %s estado got %0d exp %0d at %0t", tag, estado, e.st, $time);
            end
            n_cmp++;
            assert (ocupado === (e.st != 2'd0)) else begin
                n_bad++; $error("FAIL %s ocupado got %b exp %b at %0t", tag, ocupado, (e.st != 2'd0), $time);
            end
            n_cmp++;
            assert (dif.dato_ready === e.rdy) else begin
                n_bad++; $error("FAIL %s dato_ready got %b exp %b at %0t", tag, dif.dato_ready, e.rdy, $time);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // request from IDLE, then 4 training words; the last training cycle accepts w
    task automatic wake_seq(input logic [7:0] w);
        enb = 1'b1;
        dif.dato_valid = 1'b1;
        dif.dato_in = w;
        push(1'b0, 1'b1, 2'd0, 1'b0);
        step("wake_req");
        for (int wi = 0; wi < 4; wi++) begin
            for (int b = 0; b < 8; b++) begin
                push(train_v[b], 1'b0, 2'd1, (wi == 3 && b == 7));
                step("train");
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        enb = 1'b0;
        dif.dato_valid = 1'b0;
        dif.dato_in = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(1'b0, 1'b1, 2'd0, 1'b0);
        step("reset");

        // valid without enable must not wake the line
        dif.dato_valid = 1'b1;
        dif.dato_in = 8'hA5;
        push(1'b0, 1'b1, 2'd0, 1'b0);
        step("idle_noenb");

        // wake, then A5, 01, FF back-to-back
        wake_seq(8'hA5);
        w_v = 8'hA5;
        for (int b = 0; b < 8; b++) begin
            push(w_v[b], 1'b0, 2'd2, (b == 7));
            step("data_a5");
            if (b == 0) dif.dato_in = 8'h01;
        end
        w_v = 8'h01;
        for (int b = 0; b < 8; b++) begin
            push(w_v[b], 1'b0, 2'd2, (b == 7));
            step("b2b_01");
            if (b == 0) dif.dato_in = 8'hFF;
        end
        w_v = 8'hFF;
        for (int b = 0; b < 8; b++) begin
            push(w_v[b], 1'b0, 2'd2, (b == 7));
            step("b2b_ff");
            if (b == 6) dif.dato_valid = 1'b0;
        end

        // starve for two cycles, recover with 80 and no retraining
        push(1'b0, 1'b0, 2'd3, 1'b1);
        step("starve_hold1");
        dif.dato_valid = 1'b1;
        dif.dato_in = 8'h80;
        push(1'b0, 1'b0, 2'd3, 1'b1);
        step("starve_hold2");
        dif.dato_valid = 1'b0;
        w_v = 8'h80;
        for (int b = 0; b < 8; b++) begin
            push(w_v[b], 1'b0, 2'd2, (b == 7));
            step("recover_80");
        end

        // starve into electrical idle
        for (int h = 0; h < 4; h++) begin
            push(1'b0, 1'b0, 2'd3, 1'b1);
            step("hold_to_idle");
        end
        push(1'b0, 1'b1, 2'd0, 1'b0);
        step("idle_after_hold");

        // reset at bit 3 of a data word
        wake_seq(8'h3C);
        dif.dato_valid = 1'b0;
        w_v = 8'h3C;
        for (int b = 0; b < 3; b++) begin
            push(w_v[b], 1'b0, 2'd2, 1'b0);
            step("data_3c");
        end
        rst = 1'b1;
        push(w_v[3], 1'b0, 2'd2, 1'b0);
        step("data_3c_bit3");
        rst = 1'b0;
        push(1'b0, 1'b1, 2'd0, 1'b0);
        step("mid_reset");

        // enable dropped mid-word: word completes, then HOLD drains to IDLE
        wake_seq(8'h5A);
        w_v = 8'h5A;
        for (int b = 0; b < 8; b++) begin
            push(w_v[b], 1'b0, 2'd2, 1'b0);
            step("enb_off_word");
            if (b == 2) enb = 1'b0;
        end
        for (int h = 0; h < 4; h++) begin
            push(1'b0, 1'b0, 2'd3, 1'b0);
            step("enb_off_hold");
        end
        for (int i = 0; i < 2; i++) begin
            push(1'b0, 1'b1, 2'd0, 1'b0);
            step("enb_off_idle");
        end

        n_cmp++;
        assert (sb_q.size() == 0) else begin
            n_bad++; $error("FAIL scoreboard_drain left %0d exp 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
